// File: rtl/rx_dispatch.sv
// Receive-side frame dispatcher: classifies each MAC frame during a fixed
// 24-byte delay and forwards UDP/IPv4 frames to the UDP path, ARP frames to the ARP path.
module rx_dispatch #(
    parameter int MAC_FILT_EN = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [47:0]      local_mac,
    input  logic [7:0]       rx_din,
    input  logic             rx_din_en,
    output logic [7:0]       udp_dout,
    output logic             udp_dout_en,
    input  logic             udp_pfull,
    output logic [7:0]       arp_dout,
    output logic             arp_dout_en,
    input  logic             arp_pfull,
    output logic [CNT_W-1:0] udp_frm_cnt,
    output logic [CNT_W-1:0] arp_frm_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int unsigned DLY = 24;

    typedef enum logic [1:0] {CLS_DROP, CLS_UDP, CLS_ARP} cls_t;
    typedef enum logic [1:0] {IDLE, UDP_S, ARP_S, DROP_S} state_t;

    logic        en_q;
    logic        in_frm;
    logic        sof;
    logic [4:0]  idx_q;
    logic [4:0]  cur_idx;
    logic [7:0]  mac_byte;
    logic        uc_q;
    logic        bc_q;
    logic        mac_ok;
    logic [7:0]  et_hi_q;
    logic        et_ip_q;
    logic        et_arp_q;
    cls_t        cls_q;

    logic [DLY-1:0][7:0] dly_data;
    logic [DLY-1:0]      dly_en;
    logic [DLY-1:0]      dly_sof;
    logic [7:0]          tail_data;
    logic                tail_en;
    logic                tail_sof;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  udp_d;
    logic        udp_en_d;
    logic [7:0]  arp_d;
    logic        arp_en_d;
    logic        inc_udp;
    logic        inc_arp;
    logic        inc_drop;

    assign sof     = rx_din_en & ~en_q;
    assign cur_idx = sof ? 5'd0 : idx_q;
    assign mac_ok  = (MAC_FILT_EN == 0) || uc_q || bc_q;

    always_comb begin
        mac_byte = '0;
        case (cur_idx)
            5'd0:    mac_byte = local_mac[47:40];
            5'd1:    mac_byte = local_mac[39:32];
            5'd2:    mac_byte = local_mac[31:24];
            5'd3:    mac_byte = local_mac[23:16];
            5'd4:    mac_byte = local_mac[15:8];
            5'd5:    mac_byte = local_mac[7:0];
            default: mac_byte = '0;
        endcase
    end

    // en_q resets high so a frame already running at reset release never produces a SOF
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q     <= 1'b1;
            in_frm   <= 1'b0;
            idx_q    <= '0;
            uc_q     <= 1'b0;
            bc_q     <= 1'b0;
            et_hi_q  <= '0;
            et_ip_q  <= 1'b0;
            et_arp_q <= 1'b0;
            cls_q    <= CLS_DROP;
        end else begin
            en_q <= rx_din_en;
            if (!rx_din_en) begin
                in_frm <= 1'b0;
            end else if (sof) begin
                in_frm <= 1'b1;
            end
            if (rx_din_en && (sof || in_frm)) begin
                idx_q <= (cur_idx == 5'd24) ? 5'd24 : cur_idx + 5'd1;
                if (sof) begin
                    cls_q <= CLS_DROP;
                end
                if (cur_idx == 5'd0) begin
                    uc_q <= (rx_din == mac_byte);
                    bc_q <= (rx_din == 8'hFF);
                end else if (cur_idx <= 5'd5) begin
                    uc_q <= uc_q & (rx_din == mac_byte);
                    bc_q <= bc_q & (rx_din == 8'hFF);
                end
                if (cur_idx == 5'd12) begin
                    et_hi_q <= rx_din;
                end
                if (cur_idx == 5'd13) begin
                    et_ip_q  <= (et_hi_q == 8'h08) && (rx_din == 8'h00);
                    et_arp_q <= (et_hi_q == 8'h08) && (rx_din == 8'h06);
                end
                if (cur_idx == 5'd23) begin
                    if (mac_ok && et_arp_q) begin
                        cls_q <= CLS_ARP;
                    end else if (mac_ok && et_ip_q && (rx_din == 8'h11)) begin
                        cls_q <= CLS_UDP;
                    end else begin
                        cls_q <= CLS_DROP;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_data <= '0;
            dly_en   <= '0;
            dly_sof  <= '0;
        end else begin
            dly_data <= {dly_data[DLY-2:0], rx_din};
            dly_en   <= {dly_en[DLY-2:0], rx_din_en};
            dly_sof  <= {dly_sof[DLY-2:0], sof};
        end
    end

    assign tail_data = dly_data[DLY-1];
    assign tail_en   = dly_en[DLY-1];
    assign tail_sof  = dly_sof[DLY-1];

    // The class register is final exactly when the SOF byte reaches the tail
    always_comb begin
        state_d  = state_q;
        udp_d    = '0;
        udp_en_d = 1'b0;
        arp_d    = '0;
        arp_en_d = 1'b0;
        inc_udp  = 1'b0;
        inc_arp  = 1'b0;
        inc_drop = 1'b0;
        case (state_q)
            IDLE: begin
                if (tail_sof) begin
                    if (cls_q == CLS_UDP && !udp_pfull) begin
                        state_d  = UDP_S;
                        udp_en_d = 1'b1;
                        udp_d    = tail_data;
                        inc_udp  = 1'b1;
                    end else if (cls_q == CLS_ARP && !arp_pfull) begin
                        state_d  = ARP_S;
                        arp_en_d = 1'b1;
                        arp_d    = tail_data;
                        inc_arp  = 1'b1;
                    end else begin
                        state_d  = DROP_S;
                        inc_drop = 1'b1;
                    end
                end
            end
            UDP_S: begin
                if (tail_en) begin
                    udp_en_d = 1'b1;
                    udp_d    = tail_data;
                end else begin
                    state_d = IDLE;
                end
            end
            ARP_S: begin
                if (tail_en) begin
                    arp_en_d = 1'b1;
                    arp_d    = tail_data;
                end else begin
                    state_d = IDLE;
                end
            end
            DROP_S: begin
                if (!tail_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            udp_dout    <= '0;
            udp_dout_en <= 1'b0;
            arp_dout    <= '0;
            arp_dout_en <= 1'b0;
            udp_frm_cnt <= '0;
            arp_frm_cnt <= '0;
            drop_cnt    <= '0;
        end else begin
            state_q     <= state_d;
            udp_dout    <= udp_d;
            udp_dout_en <= udp_en_d;
            arp_dout    <= arp_d;
            arp_dout_en <= arp_en_d;
            if (inc_udp) begin
                udp_frm_cnt <= udp_frm_cnt + CNT_W'(1);
            end
            if (inc_arp) begin
                arp_frm_cnt <= arp_frm_cnt + CNT_W'(1);
            end
            if (inc_drop) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/rx_dispatch.md
Name: rx_dispatch

Overview:
- Receive-side counterpart of the UDP/ARP transmit arbiter.
- Accepts one byte-wide Ethernet frame stream from the 1G MAC receive path, then classifies each frame by destination MAC, EtherType and IPv4 protocol.
- Forwards UDP/IPv4 frames to the UDP receive path and ARP frames to the ARP responder. All other frames are dropped.
- Runs through a fixed 24-byte delay line, so every frame is classified before its first byte is emitted.

Parameters:
MAC_FILT_EN, 1, 1 = accept only frames whose destination is local_mac or FF:FF:FF:FF:FF:FF; 0 = accept any destination
CNT_W, 16, width of the status frame counters

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
local_mac  input  48  station MAC address; byte 0 is bits [47:40]
rx_din  input  8  received frame byte, first byte is destination MAC byte 0, no preamble, FCS included
rx_din_en  input  1  high for every byte of a frame, contiguous; at least 1 low cycle between frames
udp_dout  output  8  UDP frame byte
udp_dout_en  output  1  UDP frame valid, contiguous per frame
udp_pfull  input  1  UDP sink nearly full
arp_dout  output  8  ARP frame byte
arp_dout_en  output  1  ARP frame valid, contiguous per frame
arp_pfull  input  1  ARP sink nearly full
udp_frm_cnt  output  CNT_W  frames forwarded to UDP, wraps
arp_frm_cnt  output  CNT_W  frames forwarded to ARP, wraps
drop_cnt  output  CNT_W  frames dropped, wraps

Behaviour:
- Reset (async): all outputs go to 0. Delay line, byte index, class register and counters are cleared. The registered copy of rx_din_en is set to 1, so a frame already in progress at reset release is ignored until rx_din_en goes low.
- SOF: rx_din_en high while its registered copy is low. On SOF, the byte index restarts at 0 and the class register is set to DROP. The byte index saturates at 24.
- Classification while the frame is input, with flags registered per byte:
  - Bytes 0-5: compared against local_mac and against broadcast.
  - Bytes 12-13: EtherType.
  - Byte 23: IPv4 protocol.
- Decision at byte 23, registered on that edge:
  - ARP if the MAC check passes and EtherType = 0x0806.
  - UDP if the MAC check passes, EtherType = 0x0800 and byte 23 = 0x11.
  - Otherwise DROP.
- Runt frames (shorter than 24 bytes) never reach byte 23 and remain DROP.
- Delay line: 24 stages carrying {en, data, sof}. Output registers add 1 more stage.
- Latency: output byte k appears exactly 25 cycles after input byte k was sampled.
- Output FSM states: IDLE, UDP_S, ARP_S, DROP_S.
  - IDLE: when the SOF stage leaves the delay line, sample the class register and the pfull inputs.
  - UDP and !udp_pfull -> UDP_S; ARP and !arp_pfull -> ARP_S; otherwise -> DROP_S.
  - UDP_S / ARP_S: drive delayed data onto the matching output with en = 1. Return to IDLE on the first delayed en = 0.
  - DROP_S: outputs stay 0. Return to IDLE on delayed en = 0.
- Single class register is sufficient:
  - Given the 1-cycle minimum gap, a following frame cannot reach its byte 23 before the current frame's SOF leaves the delay line.
  - A runt followed immediately by a new frame samples DROP, which is correct.
- pfull is checked only at frame start. Assertion mid-frame never truncates a forwarded frame.
- Inactive outputs are held at data = 0, en = 0. udp_dout_en and arp_dout_en are never high together.
- Counters:
  - The udp/arp counter increments once on the IDLE -> UDP_S or IDLE -> ARP_S transition.
  - drop_cnt increments once on IDLE -> DROP_S, including pfull drops and runts.
  - All counters wrap modulo 2^CNT_W.
- Back-to-back frames with a 1-cycle gap are output with the same 1-cycle gap.

Test Plan:
- UDP unicast: 60-byte frame, dst = local_mac 00:0A:35:01:02:03, EtherType 0x0800, byte 23 = 0x11 -> udp_dout_en high 60 cycles, first byte 25 cycles after input SOF, data identical; udp_frm_cnt = 1; arp_dout_en stays 0.
- ARP broadcast: 64-byte frame, dst FF:FF:FF:FF:FF:FF, EtherType 0x0806 -> 64 bytes on arp_dout; arp_frm_cnt = 1.
- Filtering: IPv4 TCP (byte 23 = 0x06), UDP to foreign MAC 00:0A:35:99:99:99, and EtherType 0x86DD -> no output enables; drop_cnt = 3. With MAC_FILT_EN = 0, the foreign-MAC UDP frame is forwarded.
- Runt then back-to-back: 20-byte ARP header, 1-cycle gap, then 60-byte UDP frame -> runt dropped (drop_cnt = 1), UDP frame forwarded intact, outputs never overlap.
- Backpressure: udp_pfull = 1 when the SOF leaves the delay line -> frame dropped, drop_cnt += 1. Next frame, udp_pfull raised at output byte 10 -> all 60 bytes still forwarded.
- Reset mid-frame: assert rst at output byte 30 of a UDP frame -> outputs 0 immediately. Release rst while rx_din_en is still high -> remainder ignored; the next frame after rx_din_en low is processed normally and counters start from 0.
